// File: rtl/cw_tx_sequencer.sv
// cw_tx_sequencer: CW transmit sequencer. Delays the debounced key by a
// selectable number of millisecond ticks so the T/R relay and PA settle before
// RF, then holds cw_power_on through a decay tail plus a programmable hang time.
// Break-in/PTT gating and a master enable sit in front of the sequencing.
module cw_tx_sequencer #(
   parameter int DELAY_MAX = 32,  // delay line depth in ms ticks (1..64)
   parameter int DECAY_MS  = 24,  // envelope decay + end margin, ms
   parameter int HANG_W    = 10,  // width of cw_hang_time_i
   parameter int CNT_W     = 11   // holds max(DELAY_MAX+DECAY_MS, 2^HANG_W-1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              millisec_pulse_i,
   input  logic              cw_enable_i,
   input  logic              breakin_enable_i,
   input  logic              ptt_in_i,
   input  logic [5:0]        cw_delay_i,
   input  logic [HANG_W-1:0] cw_hang_time_i,
   input  logic              key_raw_i,
   input  logic              key_debounced_i,
   output logic              cw_power_on_o,
   output logic              cw_keydown_o,
   output logic [1:0]        tx_state_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_KEYED = 2'd1;
   localparam logic [1:0] ST_TAIL  = 2'd2;
   localparam logic [1:0] ST_HANG  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DELAY_MAX-1:0] line_q, line_d;
   logic                 power_q, power_d;
   logic                 keydown_q, keydown_d;

   logic [6:0]           delay_eff;
   logic [CNT_W-1:0]     tail_load;
   logic [DELAY_MAX-1:0] line_in;
   logic                 tap;
   logic                 keying_ok;

   // Clamp the requested key delay into 1..DELAY_MAX and derive the tail reload.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      delay_eff = {1'b0, cw_delay_i};
      if (cw_delay_i == 6'd0) begin
         delay_eff = 7'd1;
      end else if ({1'b0, cw_delay_i} > 7'(DELAY_MAX)) begin
         delay_eff = 7'(DELAY_MAX);
      end
      tail_load = CNT_W'(delay_eff) + CNT_W'(DECAY_MS);
      keying_ok = cw_enable_i & (breakin_enable_i | ptt_in_i);
   end

   // Select the delay line tap; moving cw_delay moves the tap without touching the line.
   always_comb begin
      tap = 1'b0;
      for (int i = 0; i < DELAY_MAX; i++) begin
         if (delay_eff == 7'(i + 1)) begin
            tap = line_q[i];
         end
      end
   end

   // Shift the gated key into the delay line once per millisecond tick.
   always_comb begin
      line_in    = '0;
      line_in[0] = key_debounced_i & cw_enable_i;
      line_d     = line_q;
      if (millisec_pulse_i) begin
         line_d = (line_q << 1) | line_in;
      end
   end

   // Sequencing FSM: key press wins over counting; counters only move on ticks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!cw_enable_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (key_raw_i && keying_ok) begin
         state_d = ST_KEYED;
      end else begin
         case (state_q)
            // Key released (or keying permission lost): start the full tail.
            ST_KEYED: begin
               state_d = ST_TAIL;
               cnt_d   = tail_load;
            end
            ST_TAIL: begin
               if (millisec_pulse_i) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     // Hang time is captured here only; later changes wait for the next tail.
                     cnt_d   = CNT_W'(cw_hang_time_i);
                     state_d = (cw_hang_time_i == '0) ? ST_IDLE : ST_HANG;
                  end
               end
            end
            ST_HANG: begin
               if (millisec_pulse_i) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output requests: power follows the next state or an enabled PTT; keydown
   // is the delayed key gated by the power request already on the PA.
   always_comb begin
      power_d   = (state_d != ST_IDLE) | (ptt_in_i & cw_enable_i);
      keydown_d = tap & cw_enable_i & power_q;
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         // NOTE: the delay line is reset too, otherwise stale key history would leak into RF after reset.
         line_q    <= '0;
         power_q   <= 1'b0;
         keydown_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         power_q   <= power_d;
         keydown_q <= keydown_d;
      end
   end

   assign cw_power_on_o = power_q;
   assign cw_keydown_o  = keydown_q;
   assign tx_state_o    = state_q;

endmodule

// File: tb/tb_cw_tx_sequencer.sv
// tb_cw_tx_sequencer: directed scenarios followed by randomized traffic. A
// behavioural model predicts the outputs after every clock; the prediction is
// queued and a separate monitor pops and compares once the DUT has updated.
module tb_cw_tx_sequencer;

   localparam int DELAY_MAX = 32;
   localparam int DECAY_MS  = 24;
   localparam int HANG_W    = 10;
   localparam int CNT_W     = 11;

   logic              clk = 1'b0;
   logic              rst;
   logic              millisec_pulse;
   logic              cw_enable;
   logic              breakin_enable;
   logic              ptt_in;
   logic [5:0]        cw_delay;
   logic [HANG_W-1:0] cw_hang_time;
   logic              key_raw;
   logic              key_debounced;
   logic              cw_power_on;
   logic              cw_keydown;
   logic [1:0]        tx_state;

   cw_tx_sequencer #(
      .DELAY_MAX(DELAY_MAX), .DECAY_MS(DECAY_MS), .HANG_W(HANG_W), .CNT_W(CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .millisec_pulse_i (millisec_pulse),
      .cw_enable_i      (cw_enable),
      .breakin_enable_i (breakin_enable),
      .ptt_in_i         (ptt_in),
      .cw_delay_i       (cw_delay),
      .cw_hang_time_i   (cw_hang_time),
      .key_raw_i        (key_raw),
      .key_debounced_i  (key_debounced),
      .cw_power_on_o    (cw_power_on),
      .cw_keydown_o     (cw_keydown),
      .tx_state_o       (tx_state)
   );

   always #5 clk = ~clk;

   // Scoreboard: {tx_state, cw_power_on, cw_keydown} expected after each clock.
   logic [3:0] exp_q[$];
   logic [3:0] mon_exp;
   int         n_cmp = 0;
   int         n_bad = 0;

   // Reference model: phase 0 idle, 1 keyed, 2 tail, 3 hang; 'left' is ms remaining.
   int m_phase = 0;
   int m_left  = 0;
   bit m_power = 1'b0;
   bit m_kd    = 1'b0;
   bit hist[$];              // hist[k] = gated key sampled k+1 ticks ago

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got state=%0d power=%b keydown=%b, want state=%0d power=%b keydown=%b",
                  name, $time, act[3:2], act[1], act[0], want[3:2], want[1], want[0]);
      end
   endtask

   function automatic int eff_delay(input logic [5:0] d);
      if (d == 6'd0) return 1;
      if (int'(d) > DELAY_MAX) return DELAY_MAX;
      return int'(d);
   endfunction

   // Predict the outputs produced by the coming clock edge from the inputs now applied.
   task automatic model_step();
      int  eff;
      bit  ok;
      bit  kd_next;
      int  ph;
      int  left;
      if (rst) begin
         m_phase = 0;
         m_left  = 0;
         m_power = 1'b0;
         m_kd    = 1'b0;
         hist    = {};
         for (int i = 0; i < DELAY_MAX; i++) hist.push_back(1'b0);
         return;
      end
      eff     = eff_delay(cw_delay);
      ok      = cw_enable && (breakin_enable || ptt_in);
      kd_next = hist[eff-1] && cw_enable && m_power;
      ph      = m_phase;
      left    = m_left;
      if (!cw_enable) begin
         ph   = 0;
         left = 0;
      end else if (key_raw && ok) begin
         ph = 1;
      end else if (ph == 1) begin
         ph   = 2;
         left = eff + DECAY_MS;
      end else if ((ph == 2 || ph == 3) && millisec_pulse) begin
         if (left > 0) begin
            left = left - 1;
         end else if (ph == 2) begin
            left = int'(cw_hang_time);
            ph   = (left == 0) ? 0 : 3;
         end else begin
            ph = 0;
         end
      end
      if (millisec_pulse) begin
         hist.push_front(key_debounced && cw_enable);
         void'(hist.pop_back());
      end
      m_power = (ph != 0) || (ptt_in && cw_enable);
      m_kd    = kd_next;
      m_phase = ph;
      m_left  = left;
   endtask

   // One clock of stimulus: apply tick, predict, queue the prediction, advance.
   task automatic cyc(input bit tick);
      millisec_pulse = tick;
      model_step();
      exp_q.push_back({2'(m_phase), m_power, m_kd});
      @(posedge clk);
      #2;
   endtask

   task automatic run_ms(input int n);
      repeat (n) begin
         cyc(1'b0);
         cyc(1'b1);
      end
   endtask

   task automatic press(input bit v);
      key_raw       = v;
      key_debounced = v;
   endtask

   // Monitor: compare one prediction just after every clock edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("outputs", {tx_state, cw_power_on, cw_keydown}, mon_exp);
         end
      end
   end

   initial begin
      rst            = 1'b1;
      millisec_pulse = 1'b0;
      cw_enable      = 1'b1;
      breakin_enable = 1'b1;
      ptt_in         = 1'b0;
      cw_delay       = 6'd17;
      cw_hang_time   = 10'd100;
      press(1'b0);
      repeat (3) cyc(1'b0);
      rst = 1'b0;
      cyc(1'b0);

      // Basic keying, full tail and hang back to idle.
      press(1'b1); run_ms(60);
      press(1'b0); run_ms(150);

      // Zero hang time, then a re-press 30 ticks into the hang.
      cw_hang_time = 10'd0;
      press(1'b1); run_ms(20);
      press(1'b0); run_ms(50);
      cw_hang_time = 10'd100;
      press(1'b1); run_ms(20);
      press(1'b0); run_ms(42 + 30);
      press(1'b1); run_ms(5);
      press(1'b0); run_ms(160);

      // Break-in off: key alone does nothing, PTT enables keying and holds power.
      breakin_enable = 1'b0;
      press(1'b1); run_ms(30);
      press(1'b0); run_ms(5);
      ptt_in = 1'b1;
      press(1'b1); run_ms(30);
      press(1'b0); run_ms(10);
      ptt_in = 1'b0; run_ms(170);
      breakin_enable = 1'b1;

      // Delay clamping at both ends, and a delay change mid-transmission.
      cw_delay = 6'd0; cw_hang_time = 10'd5;
      press(1'b1); run_ms(10);
      press(1'b0); run_ms(40);
      cw_delay = 6'd63;
      press(1'b1); run_ms(40);
      press(1'b0); run_ms(70);
      cw_delay = 6'd5;
      press(1'b1); run_ms(10);
      cw_delay = 6'd20; run_ms(30);
      press(1'b0); run_ms(60);

      // Enable dropped mid-hang (PTT held), reset mid-keyed.
      cw_delay = 6'd17; cw_hang_time = 10'd100;
      press(1'b1); run_ms(20);
      press(1'b0); run_ms(50);
      ptt_in = 1'b1; cw_enable = 1'b0;
      repeat (3) cyc(1'b0);
      cyc(1'b1);
      ptt_in = 1'b0; cw_enable = 1'b1; run_ms(5);
      press(1'b1); run_ms(25);
      rst = 1'b1; cyc(1'b0); cyc(1'b1);
      rst = 1'b0; run_ms(30);
      press(1'b0); run_ms(40);

      // Randomized traffic.
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 79) == 0) key_raw = ~key_raw;
         if ($urandom_range(0, 9) != 0) key_debounced = key_raw;
         if ($urandom_range(0, 299) == 0) ptt_in = ~ptt_in;
         if ($urandom_range(0, 499) == 0) breakin_enable = ~breakin_enable;
         if ($urandom_range(0, 699) == 0) cw_enable = 1'b0;
         else if ($urandom_range(0, 19) == 0) cw_enable = 1'b1;
         if ($urandom_range(0, 399) == 0) cw_delay = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 299) == 0) cw_hang_time = HANG_W'($urandom_range(0, 40));
         rst = ($urandom_range(0, 1999) == 0);
         cyc($urandom_range(0, 3) == 0);
      end
      rst = 1'b0;

      #5;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
